// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data_memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    SCAN_ACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_SCAN = 1'b1
  } owner_t;

  // dm_ctrl size/sign codes understood by data_memory
  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of CPU, scan-engine and data_memory signals around the arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface dm_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [2:0]       cpu_dm_ctrl;
  logic             cpu_ack;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  logic             scan_start;
  logic [31:0]      scan_base;
  logic             scan_busy;
  logic             scan_wr_en;
  logic [IDX_W-1:0] scan_idx;
  logic [31:0]      scan_data;
  logic             scan_done;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [2:0]       mem_dm_ctrl;
  logic [31:0]      mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  scan_start, scan_base,
    output scan_busy, scan_wr_en, scan_idx, scan_data, scan_done,
    output mem_addr, mem_wdata, mem_we, mem_dm_ctrl,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output scan_start, scan_base,
    input  scan_busy, scan_wr_en, scan_idx, scan_data, scan_done,
    input  mem_addr, mem_wdata, mem_we, mem_dm_ctrl,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Arbiter for the single data_memory port, shared between the CPU load/store
// stage and the VGA debug-buffer scan engine. Ties alternate between owners;
// the scan engine streams SCAN_WORDS consecutive words per burst.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int SCAN_WORDS = 8,
  parameter int IDX_W      = (SCAN_WORDS > 1) ? $clog2(SCAN_WORDS) : 1
) (
  input  logic        clk,
  input  logic        rst,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CPU  = CPU_ACC;
  localparam logic [1:0] ST_SCAN = SCAN_ACC;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCAN_WORDS - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  owner_t           last_owner;
  logic             scan_busy_q;
  logic             scan_done_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      scan_base_q;

  logic             cpu_elig;
  logic             scan_elig;
  logic             scan_last;
  logic [31:0]      scan_addr;

  // The final word of a burst must not re-grant the scan engine, since its
  // busy flag only clears at the edge that ends that access.
  assign scan_last = (state == ST_SCAN) && (idx == LAST_IDX);
  assign cpu_elig  = bus.cpu_req && (state != ST_CPU);
  assign scan_elig = scan_busy_q && !scan_last;
  assign scan_addr = (scan_base_q & 32'hFFFF_FFFC) + (32'(idx) << 2);

  // Pick the next owner; on a tie the side not served most recently wins.
  always_comb begin
    state_next = ST_IDLE;
    if (cpu_elig && scan_elig)
      state_next = (last_owner == OWN_SCAN) ? ST_CPU : ST_SCAN;
    else if (cpu_elig)
      state_next = ST_CPU;
    else if (scan_elig)
      state_next = ST_SCAN;
  end

  // Register the grant and remember who received it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= OWN_SCAN;
    end else begin
      state <= state_next;
      if (state_next == ST_CPU)
        last_owner <= OWN_CPU;
      else if (state_next == ST_SCAN)
        last_owner <= OWN_SCAN;
    end
  end

  // Scan burst bookkeeping: start latch, word index and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
      idx         <= '0;
      scan_base_q <= '0;
    end else begin
      scan_done_q <= 1'b0;
      if (scan_last) begin
        scan_busy_q <= 1'b0;
        scan_done_q <= 1'b1;
        idx         <= '0;
      end else if (state == ST_SCAN) begin
        idx <= idx + 1'b1;
      end
      if (bus.scan_start && !scan_busy_q) begin
        scan_base_q <= bus.scan_base;
        idx         <= '0;
        scan_busy_q <= 1'b1;
      end
    end
  end

  // Steer the memory port from whichever side owns the current cycle.
  always_comb begin
    bus.mem_addr    = 32'h0;
    bus.mem_wdata   = 32'h0;
    bus.mem_we      = 1'b0;
    bus.mem_dm_ctrl = DM_LW;
    case (state)
      ST_CPU: begin
        bus.mem_addr    = bus.cpu_addr;
        bus.mem_wdata   = bus.cpu_wdata;
        bus.mem_we      = bus.cpu_we;
        bus.mem_dm_ctrl = bus.cpu_dm_ctrl;
      end
      ST_SCAN: begin
        bus.mem_addr = scan_addr;
      end
      default: ;
    endcase
  end

  assign bus.cpu_ack    = (state == ST_CPU);
  assign bus.cpu_rdata  = bus.cpu_ack ? bus.mem_rdata : 32'h0;
  assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_ack;
  assign bus.scan_busy  = scan_busy_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.scan_wr_en = (state == ST_SCAN);
  assign bus.scan_idx   = idx;
  assign bus.scan_data  = bus.scan_wr_en ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a byte-addressable memory model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dm_arbiter_if #(.IDX_W(3)) bus ();

  dm_arbiter #(.SCAN_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // data_memory model: combinational read, write at posedge
  logic [31:0] mem     [0:127];
  logic [31:0] exp_mem [0:127];

  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  // Commit stores with byte/half/word granularity
  always @(posedge clk) begin
    if (bus.mem_we) begin
      case (bus.mem_dm_ctrl[1:0])
        2'b00:   mem[bus.mem_addr[8:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
        2'b01:   mem[bus.mem_addr[8:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
        default: mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      endcase
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cpu_req     = v.req;
    bus.cpu_we      = v.we;
    bus.cpu_addr    = v.addr;
    bus.cpu_wdata   = v.wdata;
    bus.cpu_dm_ctrl = v.ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuIdle();
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = 32'h0;
    bus.cpu_wdata   = 32'h0;
    bus.cpu_dm_ctrl = DM_LW;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  wr_cnt;
    bit  seen;

    for (int i = 0; i < 128; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      exp_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[0] = 32'h12345678; mem[1] = 32'hABCDEF00; mem[2] = 32'h00000064;
    mem[3] = 32'hFFFFFFFF; mem[4] = 32'h000000FF; mem[5] = 32'h80000000;
    for (int i = 0; i < 6; i++) exp_mem[i] = mem[i];

    //            req we  addr   wdata  ctrl    ack stall rdata         mwe maddr  mwdata ctrl
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h00, DM_LW, 1'b0, 1'b0, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};
    vecs[1]  = '{1'b1, 1'b0, 32'h08, 32'h00, DM_LW, 1'b0, 1'b1, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};
    vecs[2]  = '{1'b1, 1'b0, 32'h08, 32'h00, DM_LW, 1'b1, 1'b0, 32'h00000064,  1'b0, 32'h08, 32'h00, DM_LW};
    vecs[3]  = '{1'b1, 1'b1, 32'h01, 32'hAA, DM_LB, 1'b0, 1'b1, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};
    vecs[4]  = '{1'b1, 1'b1, 32'h01, 32'hAA, DM_LB, 1'b1, 1'b0, 32'h12345678,  1'b1, 32'h01, 32'hAA, DM_LB};
    vecs[5]  = '{1'b1, 1'b0, 32'h00, 32'h00, DM_LW, 1'b0, 1'b1, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 32'h00, DM_LW, 1'b1, 1'b0, 32'h1234AA78,  1'b0, 32'h00, 32'h00, DM_LW};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 32'h00, DM_LW, 1'b0, 1'b0, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};
    vecs[8]  = '{1'b1, 1'b0, 32'h0C, 32'h00, 3'b111, 1'b0, 1'b1, 32'h0,        1'b0, 32'h00, 32'h00, DM_LW};
    vecs[9]  = '{1'b1, 1'b0, 32'h0C, 32'h00, 3'b111, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0C, 32'h00, 3'b111};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h00, DM_LW, 1'b0, 1'b0, 32'h0,         1'b0, 32'h00, 32'h00, DM_LW};

    // Reset state, with a pending CPU request to observe stall=req
    cpuIdle();
    bus.cpu_req    = 1'b1;
    bus.scan_start = 1'b0;
    bus.scan_base  = 32'h0;
    @(negedge clk);
    checkOutput("rst ack",   32'(bus.cpu_ack), 32'h0);
    checkOutput("rst stall", 32'(bus.cpu_stall), 32'h1);
    checkOutput("rst mctrl", 32'(bus.mem_dm_ctrl), 32'h2);
    checkOutput("rst maddr", bus.mem_addr, 32'h0);
    checkOutput("rst busy",  32'(bus.scan_busy), 32'h0);
    tick();
    rst = 1'b0;
    cpuIdle();

    $display("[TB] CPU vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d ack", i),    32'(bus.cpu_ack),     32'(vecs[i].ack));
      checkOutput($sformatf("v%0d stall", i),  32'(bus.cpu_stall),   32'(vecs[i].stall));
      checkOutput($sformatf("v%0d rdata", i),  bus.cpu_rdata,        vecs[i].rdata);
      checkOutput($sformatf("v%0d mwe", i),    32'(bus.mem_we),      32'(vecs[i].mem_we));
      checkOutput($sformatf("v%0d maddr", i),  bus.mem_addr,         vecs[i].mem_addr);
      checkOutput($sformatf("v%0d mwdata", i), bus.mem_wdata,        vecs[i].mem_wdata);
      checkOutput($sformatf("v%0d mctrl", i),  32'(bus.mem_dm_ctrl), 32'(vecs[i].mem_ctrl));
      tick();
    end
    exp_mem[0] = 32'h1234AA78;

    $display("[TB] scan burst, CPU idle");
    bus.scan_base  = 32'h0;
    bus.scan_start = 1'b1;
    @(negedge clk);
    checkOutput("s3 pre busy", 32'(bus.scan_busy), 32'h0);
    tick();
    bus.scan_start = 1'b0;
    @(negedge clk);
    checkOutput("s3 busy", 32'(bus.scan_busy), 32'h1);
    checkOutput("s3 wr_en idle", 32'(bus.scan_wr_en), 32'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("s3 wr_en%0d", k), 32'(bus.scan_wr_en), 32'h1);
      checkOutput($sformatf("s3 idx%0d", k),   32'(bus.scan_idx), 32'(k));
      checkOutput($sformatf("s3 data%0d", k),  bus.scan_data, exp_mem[k]);
      checkOutput($sformatf("s3 addr%0d", k),  bus.mem_addr, 32'(4 * k));
      checkOutput($sformatf("s3 mwe%0d", k),   32'(bus.mem_we), 32'h0);
      checkOutput($sformatf("s3 busy%0d", k),  32'(bus.scan_busy), 32'h1);
      checkOutput($sformatf("s3 done%0d", k),  32'(bus.scan_done), 32'h0);
      tick();
    end
    @(negedge clk);
    checkOutput("s3 done", 32'(bus.scan_done), 32'h1);
    checkOutput("s3 end busy", 32'(bus.scan_busy), 32'h0);
    checkOutput("s3 end wr_en", 32'(bus.scan_wr_en), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("s3 done drop", 32'(bus.scan_done), 32'h0);
    tick();

    $display("[TB] scan burst with continuous CPU loads");
    bus.scan_base   = 32'h0;
    bus.scan_start  = 1'b1;
    bus.cpu_req     = 1'b1;
    bus.cpu_addr    = 32'h10;
    @(negedge clk);
    checkOutput("s4 first ack", 32'(bus.cpu_ack), 32'h0);
    tick();
    bus.scan_start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j % 2 == 0) begin
        checkOutput($sformatf("s4 ack%0d", j),   32'(bus.cpu_ack), 32'h1);
        checkOutput($sformatf("s4 rdata%0d", j), bus.cpu_rdata, 32'h000000FF);
        checkOutput($sformatf("s4 wr%0d", j),    32'(bus.scan_wr_en), 32'h0);
      end else begin
        checkOutput($sformatf("s4 ack%0d", j),   32'(bus.cpu_ack), 32'h0);
        checkOutput($sformatf("s4 stall%0d", j), 32'(bus.cpu_stall), 32'h1);
        checkOutput($sformatf("s4 wr%0d", j),    32'(bus.scan_wr_en), 32'h1);
        checkOutput($sformatf("s4 idx%0d", j),   32'(bus.scan_idx), 32'(j / 2));
        checkOutput($sformatf("s4 data%0d", j),  bus.scan_data, exp_mem[j / 2]);
      end
      tick();
    end
    @(negedge clk);
    checkOutput("s4 tail ack", 32'(bus.cpu_ack), 32'h1);
    checkOutput("s4 done", 32'(bus.scan_done), 32'h1);
    checkOutput("s4 busy", 32'(bus.scan_busy), 32'h0);
    tick();
    cpuIdle();
    @(negedge clk);
    checkOutput("s4 quiet ack", 32'(bus.cpu_ack), 32'h0);
    checkOutput("s4 quiet done", 32'(bus.scan_done), 32'h0);
    tick();

    $display("[TB] wrapped base, ignored restart, store before scan");
    bus.scan_base   = 32'hFC;
    bus.scan_start  = 1'b1;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_addr    = 32'h118;
    bus.cpu_wdata   = 32'hDEADBEEF;
    bus.cpu_dm_ctrl = DM_LW;
    @(negedge clk);
    checkOutput("s5 stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    bus.scan_base  = 32'h0;
    bus.scan_start = 1'b1;
    @(negedge clk);
    checkOutput("s5 ack", 32'(bus.cpu_ack), 32'h1);
    checkOutput("s5 mwe", 32'(bus.mem_we), 32'h1);
    checkOutput("s5 maddr", bus.mem_addr, 32'h118);
    tick();
    exp_mem[70] = 32'hDEADBEEF;
    cpuIdle();
    bus.scan_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("s5 wr%0d", k),   32'(bus.scan_wr_en), 32'h1);
      checkOutput($sformatf("s5 addr%0d", k), bus.mem_addr, 32'hFC + 32'(4 * k));
      checkOutput($sformatf("s5 idx%0d", k),  32'(bus.scan_idx), 32'(k));
      checkOutput($sformatf("s5 data%0d", k), bus.scan_data, exp_mem[63 + k]);
      tick();
    end
    @(negedge clk);
    checkOutput("s5 done", 32'(bus.scan_done), 32'h1);
    tick();

    $display("[TB] reset during CPU store");
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_addr    = 32'h14;
    bus.cpu_wdata   = 32'h11111111;
    bus.cpu_dm_ctrl = DM_LW;
    @(negedge clk);
    checkOutput("s6 stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("s6 mwe before", 32'(bus.mem_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("s6 mwe", 32'(bus.mem_we), 32'h0);
    checkOutput("s6 ack", 32'(bus.cpu_ack), 32'h0);
    checkOutput("s6 stall rst", 32'(bus.cpu_stall), 32'h1);
    checkOutput("s6 maddr", bus.mem_addr, 32'h0);
    checkOutput("s6 mwdata", bus.mem_wdata, 32'h0);
    checkOutput("s6 mctrl", 32'(bus.mem_dm_ctrl), 32'h2);
    checkOutput("s6 rdata", bus.cpu_rdata, 32'h0);
    checkOutput("s6 wr_en", 32'(bus.scan_wr_en), 32'h0);
    checkOutput("s6 idx", 32'(bus.scan_idx), 32'h0);
    checkOutput("s6 sdata", bus.scan_data, 32'h0);
    tick();
    checkOutput("s6 word kept", mem[5], exp_mem[5]);
    cpuIdle();
    rst = 1'b0;
    tick();

    $display("[TB] CPU wins the first tie after reset");
    bus.scan_base  = 32'h10;
    bus.scan_start = 1'b1;
    @(negedge clk);
    checkOutput("s7 stall", 32'(bus.cpu_stall), 32'h0);
    tick();
    bus.scan_start  = 1'b0;
    bus.cpu_req     = 1'b1;
    bus.cpu_addr    = 32'h0;
    @(negedge clk);
    checkOutput("s7 wait wr", 32'(bus.scan_wr_en), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("s7 tie ack", 32'(bus.cpu_ack), 32'h1);
    checkOutput("s7 tie rdata", bus.cpu_rdata, 32'h1234AA78);
    tick();
    cpuIdle();
    wr_cnt = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.scan_wr_en) wr_cnt++;
      if (bus.scan_done) seen = 1'b1;
      tick();
    end
    checkOutput("s7 done seen", 32'(seen), 32'h1);
    checkOutput("s7 words", 32'(wr_cnt), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
